rv_ibus_ctrl: RTL and testbench

RV_IBUS_CTRL -- requirements
Module: rv_ibus_ctrl

---
 rtl/rv_ibus_ctrl.sv | 108 ++++++++++
 tb/tb_rv_ibus_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ibus_ctrl.sv
// Instruction-fetch bus master for a pipelined bus: streams sequential word requests,
// tracks outstanding responses and discards the stale ones after a redirect.
module rv_ibus_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_INC        = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_addr,
    input  logic        i_cyc,
    input  logic        i_flush,
    output logic [31:0] o_instruction,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_mem_cyc,
    output logic        o_mem_stb,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_stall,
    input  logic        i_mem_ack,
    input  logic        i_mem_err,
    input  logic [31:0] i_mem_data
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]   INC     = 32'(ADDR_INC);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] disc_cnt;
    logic [CW-1:0] out_nxt;
    logic [31:0]   req_addr;
    logic          accept;
    logic          resp;
    logic          fwd;

    // Bus-side outputs decode only flops, so they never follow the fetch inputs combinationally.
    assign o_mem_stb  = (state == ISSUE) || (state == FLUSH);
    assign o_mem_addr = req_addr;
    assign o_mem_cyc  = (state != IDLE) || (out_cnt != '0);

    // NOTE: every signal in this always_comb is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        accept  = o_mem_stb && !i_mem_stall;
        resp    = (i_mem_ack || i_mem_err) && (out_cnt != '0);
        fwd     = resp && (disc_cnt == '0) && !i_flush;
        out_nxt = out_cnt + CW'(accept) - CW'(resp);
    end

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            out_cnt       <= '0;
            disc_cnt      <= '0;
            req_addr      <= '0;
            o_ack         <= 1'b0;
            o_err         <= 1'b0;
            o_instruction <= '0;
        end else begin
            out_cnt       <= out_nxt;
            o_ack         <= fwd && i_mem_ack;
            o_err         <= fwd && i_mem_err;
            o_instruction <= (fwd && i_mem_ack) ? i_mem_data : '0;

            if (accept)
                req_addr <= req_addr + INC;

            // Everything still in flight at a redirect is stale, including a request accepted now.
            if (i_flush)
                disc_cnt <= out_nxt;
            else
                disc_cnt <= disc_cnt + CW'((state == FLUSH) && accept)
                                     - CW'(resp && (disc_cnt != '0));

            if (i_flush) begin
                state <= (o_mem_stb && i_mem_stall) ? FLUSH : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if ((disc_cnt == '0) && i_cyc) begin
                            req_addr <= i_addr & ~32'd3;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (accept && ((out_nxt >= MAX_CNT) || !i_cyc))
                            state <= WAIT;
                    end
                    WAIT: begin
                        if ((out_cnt < MAX_CNT) && i_cyc)
                            state <= ISSUE;
                        else if ((out_cnt == '0) && !i_cyc)
                            state <= IDLE;
                    end
                    FLUSH: begin
                        if (accept)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_ibus_ctrl.sv
// Directed testbench for rv_ibus_ctrl: inputs change and outputs are sampled 1 ns after
// each rising edge; read data is a fixed function of the request address.
module tb_rv_ibus_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_cyc = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] o_instruction;
    logic        o_ack;
    logic        o_err;
    logic        o_mem_cyc;
    logic        o_mem_stb;
    logic [31:0] o_mem_addr;
    logic        i_mem_stall = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_err = 1'b0;
    logic [31:0] i_mem_data = '0;

    int checks   = 0;
    int failures = 0;

    rv_ibus_ctrl #(.MAX_OUTSTANDING(2), .ADDR_INC(4)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_addr        (i_addr),
        .i_cyc         (i_cyc),
        .i_flush       (i_flush),
        .o_instruction (o_instruction),
        .o_ack         (o_ack),
        .o_err         (o_err),
        .o_mem_cyc     (o_mem_cyc),
        .o_mem_stb     (o_mem_stb),
        .o_mem_addr    (o_mem_addr),
        .i_mem_stall   (i_mem_stall),
        .i_mem_ack     (i_mem_ack),
        .i_mem_err     (i_mem_err),
        .i_mem_data    (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_addr = '0; i_cyc = 1'b0; i_flush = 1'b0;
        i_mem_stall = 1'b0; i_mem_ack = 1'b0; i_mem_err = 1'b0; i_mem_data = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset_n = 1'b0;
        #3;
        checks++; if ({o_mem_cyc, o_mem_stb, o_ack, o_err} !== 4'b0000) begin failures++;
            $display("FAIL reset_ctl: cyc/stb/ack/err=%b want 0000", {o_mem_cyc, o_mem_stb, o_ack, o_err}); end
        checks++; if (o_mem_addr !== 32'h0) begin failures++;
            $display("FAIL reset_addr: got %h want 00000000", o_mem_addr); end
        checks++; if (o_instruction !== 32'h0) begin failures++;
            $display("FAIL reset_instr: got %h want 00000000", o_instruction); end
        step(); step();
        i_reset_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        i_addr = 32'h100; i_cyc = 1'b1;
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_cyc !== 1'b1) begin failures++;
            $display("FAIL stream_first: stb=%b addr=%h cyc=%b want 1 00000100 1", o_mem_stb, o_mem_addr, o_mem_cyc); end
        for (int k = 0; k < 6; k++) begin
            step();
            exp = 32'h100 + 32'(4 * (k + 1));
            checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== exp) begin failures++;
                $display("FAIL stream_addr k=%0d: stb=%b addr=%h want 1 %h", k, o_mem_stb, o_mem_addr, exp); end
            checks++; if (o_ack !== (k > 0)) begin failures++;
                $display("FAIL stream_ack k=%0d: got %b want %b", k, o_ack, (k > 0)); end
            if (k > 0) begin
                exp = dat(32'h100 + 32'(4 * (k - 1)));
                checks++; if (o_instruction !== exp) begin failures++;
                    $display("FAIL stream_data k=%0d: got %h want %h", k, o_instruction, exp); end
            end
            i_mem_ack = 1'b1; i_mem_data = dat(32'h100 + 32'(4 * k));
            if (k == 5) i_cyc = 1'b0;
        end
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h114) || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL stream_stop: ack=%b instr=%h stb=%b want 1 %h 0", o_ack, o_instruction, o_mem_stb, dat(32'h114)); end
        i_mem_data = dat(32'h118);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h118)) begin failures++;
            $display("FAIL stream_last: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h118)); end
        i_mem_ack = 1'b0;
        step();
        checks++; if (o_mem_cyc !== 1'b0 || o_ack !== 1'b0) begin failures++;
            $display("FAIL stream_idle: cyc=%b ack=%b want 0 0", o_mem_cyc, o_ack); end
        clear_inputs();
    endtask

    task automatic test_max_outstanding();
        i_addr = 32'h603; i_cyc = 1'b1;
        step();
        checks++; if (o_mem_addr !== 32'h600) begin failures++;
            $display("FAIL max_mask: addr=%h want 00000600", o_mem_addr); end
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h604) begin failures++;
            $display("FAIL max_second: stb=%b addr=%h want 1 00000604", o_mem_stb, o_mem_addr); end
        step();
        checks++; if (o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL max_limit: stb=%b want 0", o_mem_stb); end
        step();
        checks++; if (o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL max_wait: stb=%b want 0", o_mem_stb); end
        i_mem_ack = 1'b1; i_mem_data = dat(32'h600);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h600) || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL max_resp1: ack=%b instr=%h stb=%b want 1 %h 0", o_ack, o_instruction, o_mem_stb, dat(32'h600)); end
        i_mem_data = dat(32'h604);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h604) || o_mem_stb !== 1'b1 || o_mem_addr !== 32'h608) begin failures++;
            $display("FAIL max_resume: ack=%b instr=%h stb=%b addr=%h want 1 %h 1 00000608", o_ack, o_instruction, o_mem_stb, o_mem_addr, dat(32'h604)); end
        i_mem_ack = 1'b0; i_cyc = 1'b0;
        step();
        checks++; if (o_mem_stb !== 1'b0 || o_ack !== 1'b0) begin failures++;
            $display("FAIL max_drop: stb=%b ack=%b want 0 0", o_mem_stb, o_ack); end
        i_mem_ack = 1'b1; i_mem_data = dat(32'h608);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h608)) begin failures++;
            $display("FAIL max_drain: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h608)); end
        i_mem_ack = 1'b0;
        step();
        checks++; if (o_mem_cyc !== 1'b0) begin failures++;
            $display("FAIL max_idle: cyc=%b want 0", o_mem_cyc); end
        clear_inputs();
    endtask

    task automatic test_stall();
        i_addr = 32'h200; i_cyc = 1'b1; i_mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h200) begin failures++;
                $display("FAIL stall_hold k=%0d: stb=%b addr=%h want 1 00000200", k, o_mem_stb, o_mem_addr); end
            if (k == 1) i_cyc = 1'b0;
        end
        i_mem_stall = 1'b0;
        step();
        checks++; if (o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL stall_single: stb=%b want 0", o_mem_stb); end
        i_mem_ack = 1'b1; i_mem_data = dat(32'h200);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h200)) begin failures++;
            $display("FAIL stall_resp: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h200)); end
        i_mem_ack = 1'b0;
        step();
        checks++; if (o_mem_cyc !== 1'b0) begin failures++;
            $display("FAIL stall_idle: cyc=%b want 0", o_mem_cyc); end
        clear_inputs();
    endtask

    task automatic test_flush_outstanding();
        i_addr = 32'h700; i_cyc = 1'b1;
        step(); step(); step();
        checks++; if (o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fl2_wait: stb=%b want 0", o_mem_stb); end
        i_flush = 1'b1; i_addr = 32'h400;
        step();
        i_flush = 1'b0;
        checks++; if (o_mem_cyc !== 1'b1 || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fl2_pending: cyc=%b stb=%b want 1 0", o_mem_cyc, o_mem_stb); end
        i_mem_ack = 1'b1; i_mem_data = dat(32'h700);
        step();
        checks++; if (o_ack !== 1'b0 || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fl2_stale1: ack=%b stb=%b want 0 0", o_ack, o_mem_stb); end
        i_mem_data = dat(32'h704);
        step();
        checks++; if (o_ack !== 1'b0 || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fl2_stale2: ack=%b stb=%b want 0 0", o_ack, o_mem_stb); end
        i_mem_ack = 1'b0;
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h400) begin failures++;
            $display("FAIL fl2_redirect: stb=%b addr=%h want 1 00000400", o_mem_stb, o_mem_addr); end
        i_cyc = 1'b0;
        step();
        i_mem_ack = 1'b1; i_mem_data = dat(32'h400);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h400)) begin failures++;
            $display("FAIL fl2_fwd: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h400)); end
        i_mem_ack = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_flush_stall();
        i_addr = 32'h300; i_cyc = 1'b1; i_mem_stall = 1'b1;
        step();
        i_flush = 1'b1; i_addr = 32'h500;
        step();
        i_flush = 1'b0;
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h300) begin failures++;
            $display("FAIL fls_hold1: stb=%b addr=%h want 1 00000300", o_mem_stb, o_mem_addr); end
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h300) begin failures++;
            $display("FAIL fls_hold2: stb=%b addr=%h want 1 00000300", o_mem_stb, o_mem_addr); end
        i_mem_stall = 1'b0;
        step();
        checks++; if (o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fls_done: stb=%b want 0", o_mem_stb); end
        i_mem_ack = 1'b1; i_mem_data = dat(32'h300);
        step();
        checks++; if (o_ack !== 1'b0 || o_mem_stb !== 1'b0) begin failures++;
            $display("FAIL fls_stale: ack=%b stb=%b want 0 0", o_ack, o_mem_stb); end
        i_mem_ack = 1'b0;
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h500) begin failures++;
            $display("FAIL fls_redirect: stb=%b addr=%h want 1 00000500", o_mem_stb, o_mem_addr); end
        i_cyc = 1'b0;
        step();
        i_mem_ack = 1'b1; i_mem_data = dat(32'h500);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h500)) begin failures++;
            $display("FAIL fls_fwd: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h500)); end
        i_mem_ack = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_flush_coincident();
        i_addr = 32'h800; i_cyc = 1'b1;
        step();
        i_cyc = 1'b0;
        step();
        i_mem_ack = 1'b1; i_mem_data = dat(32'h800); i_flush = 1'b1;
        step();
        checks++; if (o_ack !== 1'b0 || o_mem_cyc !== 1'b0) begin failures++;
            $display("FAIL flc_drop: ack=%b cyc=%b want 0 0", o_ack, o_mem_cyc); end
        i_mem_ack = 1'b0; i_flush = 1'b0; i_addr = 32'h900; i_cyc = 1'b1;
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h900) begin failures++;
            $display("FAIL flc_restart: stb=%b addr=%h want 1 00000900", o_mem_stb, o_mem_addr); end
        i_cyc = 1'b0;
        step();
        i_mem_ack = 1'b1; i_mem_data = dat(32'h900);
        step();
        checks++; if (o_ack !== 1'b1 || o_instruction !== dat(32'h900)) begin failures++;
            $display("FAIL flc_fwd: ack=%b instr=%h want 1 %h", o_ack, o_instruction, dat(32'h900)); end
        i_mem_ack = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_error_wrap();
        i_addr = 32'hFFFF_FFFC; i_cyc = 1'b1;
        step();
        checks++; if (o_mem_addr !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_first: addr=%h want fffffffc", o_mem_addr); end
        step();
        checks++; if (o_mem_stb !== 1'b1 || o_mem_addr !== 32'h0) begin failures++;
            $display("FAIL wrap_next: stb=%b addr=%h want 1 00000000", o_mem_stb, o_mem_addr); end
        i_cyc = 1'b0; i_mem_err = 1'b1; i_mem_data = 32'h1234_5678;
        step();
        checks++; if (o_err !== 1'b1 || o_ack !== 1'b0 || o_instruction !== 32'h0) begin failures++;
            $display("FAIL err_resp: err=%b ack=%b instr=%h want 1 0 00000000", o_err, o_ack, o_instruction); end
        i_mem_err = 1'b0; i_mem_ack = 1'b1; i_mem_data = dat(32'h0);
        step();
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b0 || o_instruction !== dat(32'h0)) begin failures++;
            $display("FAIL wrap_data: ack=%b err=%b instr=%h want 1 0 %h", o_ack, o_err, o_instruction, dat(32'h0)); end
        i_mem_ack = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_midburst();
        i_addr = 32'hA00; i_cyc = 1'b1;
        step(); step(); step();
        i_mem_ack = 1'b1; i_mem_data = dat(32'hA00);
        step();
        checks++; if (o_ack !== 1'b1 || o_mem_cyc !== 1'b1) begin failures++;
            $display("FAIL rst_pre: ack=%b cyc=%b want 1 1", o_ack, o_mem_cyc); end
        #2 i_reset_n = 1'b0;
        #1;
        checks++; if ({o_mem_cyc, o_mem_stb, o_ack, o_err} !== 4'b0000 || o_instruction !== 32'h0 || o_mem_addr !== 32'h0) begin failures++;
            $display("FAIL rst_async: cyc/stb/ack/err=%b instr=%h addr=%h want 0000 0 0", {o_mem_cyc, o_mem_stb, o_ack, o_err}, o_instruction, o_mem_addr); end
        i_mem_ack = 1'b0; i_cyc = 1'b0;
        step();
        i_reset_n = 1'b1;
        i_mem_ack = 1'b1; i_mem_data = dat(32'hA04);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (o_ack !== 1'b0 || o_mem_cyc !== 1'b0) begin failures++;
                $display("FAIL rst_late k=%0d: ack=%b cyc=%b want 0 0", k, o_ack, o_mem_cyc); end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_max_outstanding();
        test_stall();
        test_flush_outstanding();
        test_flush_stall();
        test_flush_coincident();
        test_error_wrap();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
